// File: rtl/fractal_pkg.sv
// Shared fixed-point helpers and FSM state type for the fractal engine.
// Fixed-point values are two's complement with FRAC fractional bits.
// Helpers work at FX_MAX bits, so callers need WIDTH + FRAC <= FX_MAX.
package fractal_pkg;

    localparam int FX_MAX = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    // 4.0 in the fixed-point format; the caller narrows it to the compare width
    function automatic logic [FX_MAX-1:0] fx_four(input int frac);
        return FX_MAX'(4) << frac;
    endfunction

    // Signed multiply realigned to the fixed-point format. Bits below
    // FRAC+WIDTH of the product are exact, so the low WIDTH bits of the
    // result are product bits [FRAC+WIDTH-1:FRAC].
    function automatic logic signed [FX_MAX-1:0] fx_mul(
        input logic signed [FX_MAX-1:0] a,
        input logic signed [FX_MAX-1:0] b,
        input int                       frac
    );
        logic signed [FX_MAX-1:0] p;
        p = a * b;
        return p >>> frac;
    endfunction

endpackage

// File: rtl/mandelbrot_iter_core.sv
// One z <- z^2 + c step plus the |z|^2 > 4 escape test, purely combinational.
module mandelbrot_iter_core
    import fractal_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 60
) (
    input  logic signed [WIDTH-1:0] zr,
    input  logic signed [WIDTH-1:0] zi,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] nzr,
    output logic signed [WIDTH-1:0] nzi,
    output logic                    escape
);

    localparam logic [WIDTH+1:0] FOUR = (WIDTH+2)'(fx_four(FRAC));

    logic [WIDTH-1:0] zr2;
    logic [WIDTH-1:0] zi2;
    logic [WIDTH-1:0] zri;
    logic [WIDTH+1:0] mag;

    assign zr2 = WIDTH'(fx_mul(FX_MAX'(zr), FX_MAX'(zr), FRAC));
    assign zi2 = WIDTH'(fx_mul(FX_MAX'(zi), FX_MAX'(zi), FRAC));
    assign zri = WIDTH'(fx_mul(FX_MAX'(zr), FX_MAX'(zi), FRAC));

    // Squares are non-negative, so they are zero-extended; two extra bits
    // keep the sum from wrapping.
    assign mag    = {2'b00, zr2} + {2'b00, zi2};
    assign escape = mag > FOUR;

    // Next z wraps modulo 2^WIDTH.
    assign nzr = zr2 - zi2 + cr;
    assign nzi = {zri[WIDTH-2:0], 1'b0} + ci;

endmodule

// File: rtl/mandelbrot_engine.sv
// Frame-sequential Mandelbrot/Julia renderer: one pixel at a time,
// one iteration per clock, results handed out over a valid/ready port.
module mandelbrot_engine
    import fractal_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int FRAC     = 60,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int MAX_ITER = 150,
    parameter int ITER_W   = 8,
    parameter int ADDR_W   = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] center_x,
    input  logic signed [WIDTH-1:0] center_y,
    input  logic signed [WIDTH-1:0] step,
    input  logic signed [WIDTH-1:0] julia_cr,
    input  logic signed [WIDTH-1:0] julia_ci,
    output logic                    busy,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [ADDR_W-1:0]       pix_addr,
    output logic [ITER_W-1:0]       pix_iter,
    output logic                    pix_inside,
    output logic                    frame_done,
    output logic [ITER_W-1:0]       center_iter
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [ADDR_W-1:0]      LAST_ADDR   = ADDR_W'(H_RES*V_RES - 1);
    localparam logic [ADDR_W-1:0]      CENTER_ADDR = ADDR_W'((V_RES/2)*H_RES + H_RES/2);
    localparam logic [COL_W-1:0]       LAST_COL    = COL_W'(H_RES - 1);
    localparam logic [ITER_W-1:0]      ITER_CAP    = ITER_W'(MAX_ITER);
    localparam logic signed [WIDTH-1:0] HALF_H     = WIDTH'(H_RES/2);
    localparam logic signed [WIDTH-1:0] HALF_V     = WIDTH'(V_RES/2);

    state_t state;

    // configuration captured on start
    logic                    mode_q;
    logic signed [WIDTH-1:0] cx_q, cy_q, step_q, jcr_q, jci_q;

    // scan position and iteration state
    logic signed [WIDTH-1:0] re0_q, re_q, im_q;
    logic signed [WIDTH-1:0] zr_q, zi_q, cr_q, ci_q;
    logic [COL_W-1:0]        col_q;
    logic [ITER_W-1:0]       iter_q;

    logic signed [WIDTH-1:0] nzr, nzi;
    logic                    escape;
    logic signed [WIDTH-1:0] setup_re0, setup_im0;
    logic signed [WIDTH-1:0] next_re, next_im;
    logic signed [WIDTH-1:0] load_re, load_im;
    logic                    at_last_col, last_pix, hs;

    mandelbrot_iter_core #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_core (
        .zr     (zr_q),
        .zi     (zi_q),
        .cr     (cr_q),
        .ci     (ci_q),
        .nzr    (nzr),
        .nzi    (nzi),
        .escape (escape)
    );

    // Top-left corner of the frame, derived from the captured centre.
    assign setup_re0 = cx_q - HALF_H * step_q;
    assign setup_im0 = cy_q + HALF_V * step_q;

    assign at_last_col = col_q == LAST_COL;
    assign last_pix    = pix_addr == LAST_ADDR;
    assign hs          = pix_valid && pix_ready;

    // Raster advance: step right, or wrap to the next row down.
    always_comb begin
        next_re = re_q + step_q;
        next_im = im_q;
        if (at_last_col) begin
            next_re = re0_q;
            next_im = im_q - step_q;
        end
    end

    // Coordinate of the pixel about to be loaded into the iterator.
    always_comb begin
        load_re = next_re;
        load_im = next_im;
        if (state == SETUP) begin
            load_re = setup_re0;
            load_im = setup_im0;
        end
    end

    // A restart suppresses the completion pulse of the frame it aborts.
    assign frame_done = hs && last_pix && !start;

    // Main FSM: start always wins and resamples the configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            pix_iter    <= '0;
            pix_inside  <= 1'b0;
            center_iter <= '0;
            mode_q      <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            step_q      <= '0;
            jcr_q       <= '0;
            jci_q       <= '0;
            re0_q       <= '0;
            re_q        <= '0;
            im_q        <= '0;
            zr_q        <= '0;
            zi_q        <= '0;
            cr_q        <= '0;
            ci_q        <= '0;
            col_q       <= '0;
            iter_q      <= '0;
        end else if (start) begin
            state     <= SETUP;
            busy      <= 1'b1;
            pix_valid <= 1'b0;
            mode_q    <= mode;
            cx_q      <= center_x;
            cy_q      <= center_y;
            step_q    <= step;
            jcr_q     <= julia_cr;
            jci_q     <= julia_ci;
        end else begin
            case (state)
                SETUP: begin
                    re0_q    <= setup_re0;
                    re_q     <= setup_re0;
                    im_q     <= setup_im0;
                    col_q    <= '0;
                    pix_addr <= '0;
                    zr_q     <= load_re;
                    zi_q     <= load_im;
                    cr_q     <= mode_q ? jcr_q : load_re;
                    ci_q     <= mode_q ? jci_q : load_im;
                    iter_q   <= '0;
                    state    <= ITER;
                end
                ITER: begin
                    if (escape) begin
                        pix_iter   <= iter_q;
                        pix_inside <= 1'b0;
                        pix_valid  <= 1'b1;
                        state      <= EMIT;
                    end else if (iter_q == ITER_CAP) begin
                        pix_iter   <= iter_q;
                        pix_inside <= 1'b1;
                        pix_valid  <= 1'b1;
                        state      <= EMIT;
                    end else begin
                        zr_q   <= nzr;
                        zi_q   <= nzi;
                        iter_q <= iter_q + ITER_W'(1);
                    end
                end
                EMIT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (pix_addr == CENTER_ADDR)
                            center_iter <= pix_iter;
                        if (last_pix) begin
                            busy     <= 1'b0;
                            pix_addr <= '0;
                            state    <= IDLE;
                        end else begin
                            pix_addr <= pix_addr + ADDR_W'(1);
                            col_q    <= at_last_col ? '0 : col_q + COL_W'(1);
                            re_q     <= next_re;
                            im_q     <= next_im;
                            zr_q     <= load_re;
                            zi_q     <= load_im;
                            cr_q     <= mode_q ? jcr_q : load_re;
                            ci_q     <= mode_q ? jci_q : load_im;
                            iter_q   <= '0;
                            state    <= ITER;
                        end
                    end
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Self-checking bench for mandelbrot_engine on a 4x2 frame.
module tb_mandelbrot_engine;

    localparam int WIDTH = 64;
    localparam int FRAC  = 60;
    localparam int H_RES = 4;
    localparam int V_RES = 2;
    localparam int MAXI  = 150;
    localparam int NPIX  = H_RES * V_RES;
    localparam logic signed [63:0] ONE = 64'h1000_0000_0000_0000;

    logic                    clk, reset, start, mode, pix_ready;
    logic signed [WIDTH-1:0] center_x, center_y, step, julia_cr, julia_ci;
    logic                    busy, pix_valid, pix_inside, frame_done;
    logic [18:0]             pix_addr;
    logic [7:0]              pix_iter, center_iter;

    int vectors = 0;
    int miscompares = 0;

    int q_addr[$];
    int q_iter[$];
    int q_in[$];
    int done_n, done_addr;
    bit timeout;

    int e_it[NPIX];
    int e_in[NPIX];

    int tbl_it[NPIX] = '{0, 2, 150, 1, 150, 150, 150, 2};
    int tbl_in[NPIX] = '{0, 0, 1, 0, 1, 1, 1, 0};

    mandelbrot_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .H_RES(H_RES), .V_RES(V_RES),
        .MAX_ITER(MAXI), .ITER_W(8), .ADDR_W(19)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .center_x(center_x), .center_y(center_y), .step(step),
        .julia_cr(julia_cr), .julia_ci(julia_ci),
        .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_addr(pix_addr), .pix_iter(pix_iter), .pix_inside(pix_inside),
        .frame_done(frame_done), .center_iter(center_iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic signed [63:0] fxm(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [127:0] p;
        p = 128'(a) * 128'(b);
        p = p >>> FRAC;
        return p[63:0];
    endfunction

    // Escape-time count of one pixel using the specified truncating arithmetic.
    task automatic model_pixel(input bit m, input logic signed [63:0] pr, input logic signed [63:0] pi,
                               input logic signed [63:0] jr, input logic signed [63:0] ji,
                               output int it, output int ins);
        logic signed [63:0] zr, zi, cr, ci, rr, ii, ri;
        logic [127:0] mag, four;
        zr = pr; zi = pi;
        cr = m ? jr : pr;
        ci = m ? ji : pi;
        four = 128'd4 << FRAC;
        it = MAXI; ins = 1;
        for (int k = 0; k <= MAXI; k++) begin
            rr = fxm(zr, zr);
            ii = fxm(zi, zi);
            ri = fxm(zr, zi);
            mag = {64'd0, rr} + {64'd0, ii};
            if (mag > four) begin it = k; ins = 0; return; end
            if (k == MAXI) begin it = k; ins = 1; return; end
            zr = rr - ii + cr;
            zi = (ri <<< 1) + ci;
        end
    endtask

    task automatic build_expect(input bit m, input logic signed [63:0] cx, input logic signed [63:0] cy,
                                input logic signed [63:0] st, input logic signed [63:0] jr,
                                input logic signed [63:0] ji);
        logic signed [63:0] re0, im0, re, im;
        re0 = cx - 64'(H_RES/2) * st;
        im0 = cy + 64'(V_RES/2) * st;
        for (int a = 0; a < NPIX; a++) begin
            re = re0 + 64'(a % H_RES) * st;
            im = im0 - 64'(a / H_RES) * st;
            model_pixel(m, re, im, jr, ji, e_it[a], e_in[a]);
        end
    endtask

    function automatic logic signed [63:0] rnd_fx(input int lo, input int hi);
        int v;
        v = lo + int'($urandom_range(0, hi - lo));
        return 64'(v) * (ONE / 100);
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic do_start(input bit m, input logic signed [63:0] cx, input logic signed [63:0] cy,
                            input logic signed [63:0] st, input logic signed [63:0] jr,
                            input logic signed [63:0] ji);
        @(posedge clk); #1;
        mode = m; center_x = cx; center_y = cy; step = st; julia_cr = jr; julia_ci = ji;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Record every handshake until busy drops (bounded).
    task automatic collect_frame(input int ready_pct);
        q_addr.delete(); q_iter.delete(); q_in.delete();
        done_n = 0; done_addr = -1; timeout = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            pix_ready = ($urandom_range(0, 99) < ready_pct);
            @(negedge clk);
            if (frame_done) begin done_n++; done_addr = int'(pix_addr); end
            if (pix_valid && pix_ready) begin
                q_addr.push_back(int'(pix_addr));
                q_iter.push_back(int'(pix_iter));
                q_in.push_back(int'(pix_inside));
            end
            if (!busy) begin timeout = 1'b0; return; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0; pix_ready = 1'b1;
        center_x = '0; center_y = '0; step = '0; julia_cr = '0; julia_ci = '0;
        #2 reset = 1'b0;
        #20;
        vectors++;
        if ({busy, pix_valid, frame_done, pix_inside} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {busy, pix_valid, frame_done, pix_inside});
        end
        vectors++;
        if (pix_addr !== 19'd0 || pix_iter !== 8'd0 || center_iter !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_values: addr=%0d iter=%0d center=%0d want 0", pix_addr, pix_iter, center_iter);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy, pix_valid);
        end
    endtask

    task automatic test_mandel_frame();
        do_start(1'b0, '0, '0, ONE, '0, '0);
        collect_frame(100);
        vectors++;
        if (timeout || q_addr.size() != NPIX) begin
            miscompares++;
            $display("FAIL mandel_count: got %0d pixels (timeout=%0d) want %0d", q_addr.size(), timeout, NPIX);
        end
        for (int i = 0; i < NPIX && i < q_addr.size(); i++) begin
            vectors++;
            if (q_addr[i] != i || q_iter[i] != tbl_it[i] || q_in[i] != tbl_in[i]) begin
                miscompares++;
                $display("FAIL mandel_pixel: got addr=%0d iter=%0d in=%0d want addr=%0d iter=%0d in=%0d",
                         q_addr[i], q_iter[i], q_in[i], i, tbl_it[i], tbl_in[i]);
            end
        end
        vectors++;
        if (done_n != 1 || done_addr != NPIX - 1) begin
            miscompares++;
            $display("FAIL mandel_done: got %0d pulses at %0d want 1 at %0d", done_n, done_addr, NPIX - 1);
        end
        vectors++;
        if (center_iter !== 8'd150) begin
            miscompares++;
            $display("FAIL mandel_center: got %0d want 150", center_iter);
        end
        vectors++;
        if (busy !== 1'b0 || pix_addr !== 19'd0) begin
            miscompares++;
            $display("FAIL mandel_end: busy=%b addr=%0d want 0 0", busy, pix_addr);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        pix_ready = 1'b0;
        do_start(1'b0, '0, '0, ONE, '0, '0);
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (pix_valid) found = 1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL bp_first: got no pix_valid want valid"); end
        pix_ready = 1'b1;
        @(posedge clk); #1 pix_ready = 1'b0;
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (pix_valid) found = 1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL bp_second: got no pix_valid want valid"); end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (pix_valid !== 1'b1 || pix_addr !== 19'd1 || pix_iter !== 8'd2 || pix_inside !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: got valid=%b addr=%0d iter=%0d in=%b want 1 1 2 0",
                         pix_valid, pix_addr, pix_iter, pix_inside);
            end
        end
        pix_ready = 1'b1;
        collect_frame(100);
        vectors++;
        if (timeout || q_addr.size() != NPIX - 2 || q_addr[0] != 2 || done_n != 1) begin
            miscompares++;
            $display("FAIL bp_resume: got n=%0d first=%0d done=%0d want n=%0d first=2 done=1",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : -1, done_n, NPIX - 2);
        end
    endtask

    task automatic test_julia();
        do_start(1'b1, '0, '0, ONE, '0, '0);
        build_expect(1'b1, '0, '0, ONE, '0, '0);
        collect_frame(100);
        vectors++;
        if (timeout || q_addr.size() != NPIX) begin
            miscompares++;
            $display("FAIL julia_count: got %0d want %0d", q_addr.size(), NPIX);
        end else begin
            vectors++;
            if (q_iter[0] != 0 || q_in[0] != 0) begin
                miscompares++; $display("FAIL julia_m2p1: got %0d/%0d want 0/0", q_iter[0], q_in[0]);
            end
            vectors++;
            if (q_iter[6] != 150 || q_in[6] != 1) begin
                miscompares++; $display("FAIL julia_origin: got %0d/%0d want 150/1", q_iter[6], q_in[6]);
            end
            vectors++;
            if (q_iter[5] != 150 || q_in[5] != 1) begin
                miscompares++; $display("FAIL julia_m1: got %0d/%0d want 150/1", q_iter[5], q_in[5]);
            end
            for (int i = 0; i < NPIX; i++) begin
                vectors++;
                if (q_addr[i] != i || q_iter[i] != e_it[i] || q_in[i] != e_in[i]) begin
                    miscompares++;
                    $display("FAIL julia_model: addr %0d got %0d/%0d want %0d/%0d",
                             q_addr[i], q_iter[i], q_in[i], e_it[i], e_in[i]);
                end
            end
        end
    endtask

    task automatic test_restart();
        bit found;
        for (int pass = 0; pass < 2; pass++) begin
            int target;
            target = (pass == 0) ? 3 : NPIX - 1;
            pix_ready = 1'b1;
            do_start(1'b0, '0, '0, ONE, '0, '0);
            found = 0;
            for (int c = 0; c < 3000 && !found; c++) begin
                @(negedge clk);
                if (pix_valid && pix_addr == 19'(target)) found = 1;
            end
            vectors++;
            if (!found) begin miscompares++; $display("FAIL restart_wait: got no addr %0d want it", target); end
            start = 1'b1;
            #1;
            vectors++;
            if (frame_done !== 1'b0) begin
                miscompares++; $display("FAIL restart_nodone: got %b want 0 at addr %0d", frame_done, target);
            end
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            vectors++;
            if (pix_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++; $display("FAIL restart_drop: valid=%b busy=%b want 0 1", pix_valid, busy);
            end
            collect_frame(100);
            vectors++;
            if (timeout || q_addr.size() != NPIX || q_addr[0] != 0 || done_n != 1 || done_addr != NPIX - 1) begin
                miscompares++;
                $display("FAIL restart_frame: got n=%0d done=%0d@%0d want n=%0d done=1@%0d",
                         q_addr.size(), done_n, done_addr, NPIX, NPIX - 1);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found, bad;
        pix_ready = 1'b1;
        do_start(1'b0, '0, '0, ONE, '0, '0);
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (busy && !pix_valid && pix_addr == 19'd2) found = 1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL areset_wait: got no ITER at addr 2 want it"); end
        @(posedge clk); #3 reset = 1'b0; #1;
        vectors++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || pix_addr !== 19'd0) begin
            miscompares++;
            $display("FAIL areset_now: busy=%b valid=%b addr=%0d want 0 0 0", busy, pix_valid, pix_addr);
        end
        vectors++;
        if (pix_iter !== 8'd0 || center_iter !== 8'd0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_vals: iter=%0d center=%0d done=%b want 0 0 0", pix_iter, center_iter, frame_done);
        end
        #2 reset = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || pix_valid) bad = 1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL areset_idle: got activity want idle until start"); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            bit m;
            logic signed [63:0] cx, cy, st, jr, ji;
            int ci;
            m  = 1'($urandom_range(0, 1));
            cx = rnd_fx(-150, 100);
            cy = rnd_fx(-120, 120);
            st = rnd_fx(1, 80);
            jr = rnd_fx(-100, 50);
            ji = rnd_fx(-80, 80);
            build_expect(m, cx, cy, st, jr, ji);
            do_start(m, cx, cy, st, jr, ji);
            collect_frame(60);
            vectors++;
            if (timeout || q_addr.size() != NPIX || done_n != 1) begin
                miscompares++;
                $display("FAIL rand_frame%0d: got n=%0d done=%0d want n=%0d done=1", f, q_addr.size(), done_n, NPIX);
            end
            for (int i = 0; i < NPIX && i < q_addr.size(); i++) begin
                vectors++;
                if (q_addr[i] != i || q_iter[i] != e_it[i] || q_in[i] != e_in[i]) begin
                    miscompares++;
                    $display("FAIL rand_pixel: frame %0d got addr=%0d %0d/%0d want addr=%0d %0d/%0d",
                             f, q_addr[i], q_iter[i], q_in[i], i, e_it[i], e_in[i]);
                end
            end
            ci = (V_RES/2) * H_RES + H_RES/2;
            vectors++;
            if (int'(center_iter) != e_it[ci]) begin
                miscompares++;
                $display("FAIL rand_center: frame %0d got %0d want %0d", f, center_iter, e_it[ci]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mandel_frame();
        test_backpressure();
        test_julia();
        test_restart();
        test_async_reset();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mandelbrot_engine.md
MANDELBROT_ENGINE -- requirements
Module: mandelbrot_engine

Interface
REQ-001 SHALL have parameter WIDTH, 64, total signed fixed-point bits.
REQ-002 SHALL have parameter FRAC, 60, fractional bits; WIDTH-FRAC >= 4.
REQ-003 SHALL have parameters H_RES and V_RES, 640 and 480, frame size in pixels.
REQ-004 SHALL have parameter MAX_ITER, 150, iteration cap; ITER_W, 8; ADDR_W, 19.
REQ-005 SHALL have port clk, in, 1: single clock.
REQ-006 SHALL have port reset, in, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, in, 1: one-cycle frame request; config sampled on it.
REQ-008 SHALL have port mode, in, 1: 0 = Mandelbrot, 1 = Julia.
REQ-009 SHALL have ports center_x, center_y, step, julia_cr, julia_ci, in, WIDTH signed: frame centre, pixel pitch, Julia constant.
REQ-010 SHALL have port busy, out, 1: frame in progress.
REQ-011 SHALL have ports pix_valid (out, 1) and pix_ready (in, 1): pixel handshake.
REQ-012 SHALL have ports pix_addr (out, ADDR_W), pix_iter (out, ITER_W) and pix_inside (out, 1): linear address, escape count, in-set flag.
REQ-013 SHALL have ports frame_done (out, 1), a one-cycle pulse, and center_iter (out, ITER_W), the count at pixel (H_RES/2, V_RES/2).

Function
REQ-014 SHALL use FSM states IDLE, SETUP, ITER, EMIT; transitions IDLE->SETUP on start, SETUP->ITER, ITER->EMIT on terminate, EMIT->ITER on handshake if pixels remain, else EMIT->IDLE.
REQ-015 SHALL compute in SETUP: re0 = center_x - (H_RES/2)*step and im0 = center_y + (V_RES/2)*step, truncated to WIDTH bits.
REQ-016 SHALL load at each pixel start: iter=0; Mandelbrot z=c, c=pixel; Julia z=pixel, c=(julia_cr, julia_ci).
REQ-017 SHALL perform one ITER cycle per iteration: products keep bits [FRAC+WIDTH-1:FRAC]; magnitude sum is formed in WIDTH+2 bits.
REQ-018 SHALL terminate in an ITER cycle if zr^2+zi^2 > 4.0 (escape; pix_inside=0) or if iter==MAX_ITER (pix_inside=1); otherwise z <= z^2+c and iter+1.
REQ-019 SHALL make pix_iter equal iter at termination, so a pixel of count k occupies k+1 ITER cycles followed by EMIT.
REQ-020 SHALL assert pix_valid only in EMIT and hold pix_addr, pix_iter and pix_inside stable until the cycle pix_valid && pix_ready.
REQ-021 SHALL, on handshake: addr+1, re+=step; at column H_RES-1, re=re0 and im-=step.
REQ-022 SHALL pulse frame_done in the handshake cycle of address H_RES*V_RES-1, deassert busy next cycle and return pix_addr to 0.
REQ-023 SHALL update center_iter in the handshake cycle of the centre pixel only.
REQ-024 SHALL treat start while busy as a restart: discard the pending pixel, resample config, go to SETUP, pix_valid low next cycle, no frame_done.
REQ-025 SHALL let start take priority over a simultaneous handshake.
REQ-026 SHALL leave busy high from the cycle after start until the cycle after frame_done.

Reset
REQ-027 SHALL, on reset low, immediately force: IDLE, busy=0, pix_valid=0, frame_done=0, pix_addr=0, pix_iter=0, pix_inside=0, center_iter=0, all coordinates and z zero.
REQ-028 SHALL require a fresh start after reset deasserts, including when reset occurs mid-frame.

Structure
REQ-029 SHALL take the state enum, the fixed-point 4.0 constant function of WIDTH/FRAC, and the fixed-point multiply/slice function from shared package fractal_pkg.
REQ-030 SHALL place the z^2+c step and escape test in sub-module mandelbrot_iter_core (combinational, parametrised WIDTH/FRAC).

Verification (H_RES=4, V_RES=2, MAX_ITER=150, FRAC=60, center 0, step 1.0, pix_ready=1)
REQ-031 SHALL cover the Mandelbrot frame: pixel iter,inside = (0,0),(2,0),(150,1),(1,0),(150,1),(150,1),(150,1),(2,0); one frame_done at addr 7; center_iter=150.
REQ-032 SHALL cover backpressure: pix_ready low 5 cycles at addr 1 -> pix_valid held, addr=1 and iter=2 stable, no advance.
REQ-033 SHALL cover Julia mode=1 with c=(0,0) -> pixel (-2,+1) gives iter 0; pixel (0,0) gives 150/inside; pixel (-1,0) gives 150/inside.
REQ-034 SHALL cover restart: start at addr 3 mid-frame -> pix_valid low next cycle, next pixel addr 0, no frame_done for the aborted frame.
REQ-035 SHALL cover async reset: reset low mid-ITER -> busy, pix_valid and pix_addr at 0 before the next clk edge; idle until start.
